sky_cycle_ctrl: RTL and testbench
=================================

Name: sky_cycle_ctrl

Overview:
- Day/night sequencer for the VGA sky scene.
- Counts frames and advances the sky through a repeating cycle: night hold, morning ramp, day hold, evening ramp.
- Drives fade_level and frame_count to the star, sky and fade generators.
- Produces a per-star twinkle enable mask that is gated off outside night.

Parameters:
HOLD_FRAMES, 120, frames spent in each hold state (>=1)
STEP_FRAMES, 2, frames per fade_level increment in ramp states (>=1)
NSTARS, 12, width of star enable mask (<=16)
LFSR_SEED, 16'hACE1, twinkle LFSR reset value (nonzero)

Ports:
clk_pix  in  1  pixel clock, the only clock
rst  in  1  synchronous, active-high reset
frame  in  1  one-cycle pulse at start of each frame (tick)
pause  in  1  level; freezes the sequencer FSM and fade_level
skip  in  1  one-cycle pulse; jump to the next hold state
fade_level  out  8  cycle position; 0 = midnight, 128 = noon
frame_count  out  16  frame counter
is_night  out  1  (fade_level < 64) || (fade_level > 208)
phase  out  2  0 NIGHT_HOLD, 1 MORNING, 2 DAY_HOLD, 3 EVENING
star_en  out  NSTARS  star_mask & {NSTARS{is_night}}

Behaviour:
- Reset, sync, has priority over all inputs. Next cycle after reset:
  - fade_level=0, frame_count=0, phase=0, star_mask=0 (so star_en=0).
  - hold_cnt=0, step_cnt=0, skip_pend=0, lfsr=LFSR_SEED.
- All state changes occur only on tick cycles (frame=1), except skip_pend capture.
- is_night and star_en are combinational decodes of registers, zero latency.
- frame_count:
  - Increments by 1 on every tick, including while paused.
  - Wraps 16'hFFFF -> 0.
- lfsr:
  - Advances on every tick, including while paused.
  - Galois right shift: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- star_mask:
  - Loads lfsr[NSTARS-1:0] (pre-advance value) on a tick where the pre-increment frame_count[3:0]==4'hF.
  - Otherwise holds.
- skip capture:
  - skip=1 sets skip_pend; a second skip while pending is a no-op.
  - Effective skip = skip_pend | skip, sampled on a tick with pause=0.
  - Effective skip is consumed (skip_pend cleared) on that tick.
- pause=1 on a tick:
  - FSM, hold_cnt, step_cnt and fade_level hold.
  - skip_pend is retained.
- FSM on a tick with pause=0 and no effective skip:
  - NIGHT_HOLD: fade=0. If hold_cnt==HOLD_FRAMES-1: hold_cnt=0, go MORNING; else hold_cnt+1.
  - MORNING: if step_cnt==STEP_FRAMES-1: step_cnt=0 and fade+1; when the new fade==128, go DAY_HOLD. Else step_cnt+1.
  - DAY_HOLD: as NIGHT_HOLD, fade=128, exit to EVENING.
  - EVENING: as MORNING; fade 255 -> 0 wraps (8-bit) and goes NIGHT_HOLD.
- Effective skip on a tick (pause=0), all counters cleared:
  - MORNING -> DAY_HOLD, fade=128.
  - EVENING -> NIGHT_HOLD, fade=0.
  - NIGHT_HOLD -> MORNING, fade stays 0.
  - DAY_HOLD -> EVENING, fade stays 128.
- Full cycle length: 2*HOLD_FRAMES + 256*STEP_FRAMES ticks (default 752).
- Reset mid-operation (any state, same cycle as tick/skip): reset wins; the pending skip is discarded.

Test Plan:
- Reset: HOLD_FRAMES=4, STEP_FRAMES=2; assert rst 2 cycles with frame=1 -> fade_level=0, frame_count=0, phase=0, is_night=1, star_en=0.
- Full cycle, same params, 520 ticks:
  - Tick 4 -> phase=1, fade=0.
  - Tick 6 -> fade=1.
  - Tick 260 -> fade=128, phase=2, is_night=0.
  - Tick 264 -> phase=3.
  - Tick 520 -> fade=0, phase=0, frame_count=520.
- Pause: in MORNING at fade=37, pause=1 for 10 ticks -> fade stays 37, phase=1, frame_count +10; after release, fade=38 exactly STEP_FRAMES ticks later.
- Skip:
  - skip pulse between ticks at MORNING fade=37 -> next tick fade=128, phase=2.
  - skip while paused -> applied on first unpaused tick.
  - skip in EVENING -> fade=0, phase=0.
- Twinkle: after 16 ticks from reset, star_mask equals lfsr after 15 advances from 16'hACE1, masked to 12 bits; star_en equals it at night and is 0 while fade in 64..208.
- Wrap and reset: preload to frame_count=16'hFFFF via 65535 ticks -> next tick 0. Assert rst during EVENING coincident with tick and skip -> reset values next cycle, no skip applied afterward.

Source files
------------

// File: rtl/sky_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// sky_cycle_ctrl_if
//   Bundle between the frame-timing side (frame tick, pause, skip) and the
//   day/night sequencer that drives the sky/star/fade generators.
//
//   Signals:
//     frame       - one-cycle pulse at the start of each frame (tick)
//     pause       - level; freezes the sequencer FSM and fade_level
//     skip        - one-cycle pulse; jump to the next hold state
//     fade_level  - cycle position, 0 = midnight, 128 = noon
//     frame_count - free-running frame counter
//     is_night    - night decode of fade_level
//     phase       - 0 NIGHT_HOLD, 1 MORNING, 2 DAY_HOLD, 3 EVENING
//     star_en     - per-star twinkle enable, zero outside night
//
//   Handshake: there is no valid/ready pair. frame qualifies every update;
//   outputs are register-backed and valid every cycle after reset.
//
//   Modports:
//     master - frame/pause/skip source, observes the sequencer outputs
//     slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface sky_cycle_ctrl_if #(
    parameter int NSTARS = 12
);
    logic              frame;
    logic              pause;
    logic              skip;
    logic [7:0]        fade_level;
    logic [15:0]       frame_count;
    logic              is_night;
    logic [1:0]        phase;
    logic [NSTARS-1:0] star_en;

    modport master (
        output frame,
        output pause,
        output skip,
        input  fade_level,
        input  frame_count,
        input  is_night,
        input  phase,
        input  star_en
    );

    modport slave (
        input  frame,
        input  pause,
        input  skip,
        output fade_level,
        output frame_count,
        output is_night,
        output phase,
        output star_en
    );
endinterface

// File: rtl/sky_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// sky_cycle_ctrl
//   Day/night sequencer for the VGA sky scene. Counts frames and walks the
//   sky through night hold -> morning ramp -> day hold -> evening ramp,
//   repeating forever. Also produces a slowly changing twinkle mask for the
//   star generator, gated off whenever it is not night.
//
//   Ports:
//     clk_pix - pixel clock, the only clock
//     rst     - synchronous active-high reset, priority over everything
//     bus     - sky_cycle_ctrl_if.slave
//               in : frame, pause, skip
//               out: fade_level, frame_count, is_night, phase, star_en
//
//   The phase output is the FSM state register itself, so the state is
//   directly observable.
//
//   Full cycle length with no pause/skip:
//     2*HOLD_FRAMES + 256*STEP_FRAMES ticks.
// ---------------------------------------------------------------------------
module sky_cycle_ctrl #(
    parameter int          HOLD_FRAMES = 120,
    parameter int          STEP_FRAMES = 2,
    parameter int          NSTARS      = 12,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic           clk_pix,
    input  logic           rst,
    sky_cycle_ctrl_if.slave bus
);

    // FSM encoding doubles as the phase output.
    localparam logic [1:0] S_NIGHT_HOLD = 2'd0;
    localparam logic [1:0] S_MORNING    = 2'd1;
    localparam logic [1:0] S_DAY_HOLD   = 2'd2;
    localparam logic [1:0] S_EVENING    = 2'd3;

    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_FRAMES - 1);

    localparam logic [7:0]  FADE_MIDNIGHT = 8'd0;
    localparam logic [7:0]  FADE_NOON     = 8'd128;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [7:0]        r_fade;
    logic [15:0]       r_frame_cnt;
    logic [15:0]       r_lfsr;
    logic [NSTARS-1:0] r_star_mask;
    logic [HW-1:0]     r_hold_cnt;
    logic [SW-1:0]     r_step_cnt;
    logic              r_skip_pend;

    // -----------------------------------------------------------------------
    // Combinational next-state
    // -----------------------------------------------------------------------
    logic              w_tick;
    logic              w_advance;
    logic              w_skip_eff;
    logic [7:0]        w_fade_inc;
    logic [15:0]       w_lfsr_adv;
    logic              w_is_night;

    logic [1:0]        w_state_nxt;
    logic [7:0]        w_fade_nxt;
    logic [HW-1:0]     w_hold_nxt;
    logic [SW-1:0]     w_step_nxt;
    logic              w_skip_pend_nxt;

    assign w_tick     = bus.frame;
    // The sequencer only moves on an unpaused tick; frame_count and the
    // LFSR keep running through pause so twinkle never freezes.
    assign w_advance  = w_tick & ~bus.pause;
    // A skip pulse on the tick itself counts the same as one captured
    // earlier between ticks.
    assign w_skip_eff = r_skip_pend | bus.skip;
    assign w_fade_inc = r_fade + 8'd1;
    assign w_lfsr_adv = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        w_state_nxt = r_state;
        w_fade_nxt  = r_fade;
        w_hold_nxt  = r_hold_cnt;
        w_step_nxt  = r_step_cnt;

        if (w_advance) begin
            if (w_skip_eff) begin
                // Skip lands on the start of the next hold (from a ramp) or
                // the start of the next ramp (from a hold); counters restart.
                w_hold_nxt = '0;
                w_step_nxt = '0;
                case (r_state)
                    S_NIGHT_HOLD: w_state_nxt = S_MORNING;
                    S_MORNING: begin
                        w_state_nxt = S_DAY_HOLD;
                        w_fade_nxt  = FADE_NOON;
                    end
                    S_DAY_HOLD:   w_state_nxt = S_EVENING;
                    default: begin
                        w_state_nxt = S_NIGHT_HOLD;
                        w_fade_nxt  = FADE_MIDNIGHT;
                    end
                endcase
            end else begin
                case (r_state)
                    S_NIGHT_HOLD, S_DAY_HOLD: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            w_hold_nxt  = '0;
                            w_state_nxt = (r_state == S_NIGHT_HOLD) ? S_MORNING : S_EVENING;
                        end else begin
                            w_hold_nxt = r_hold_cnt + HW'(1);
                        end
                    end
                    S_MORNING: begin
                        if (r_step_cnt == STEP_LAST) begin
                            w_step_nxt = '0;
                            w_fade_nxt = w_fade_inc;
                            if (w_fade_inc == FADE_NOON) begin
                                w_state_nxt = S_DAY_HOLD;
                            end
                        end else begin
                            w_step_nxt = r_step_cnt + SW'(1);
                        end
                    end
                    default: begin
                        // Evening runs 128 -> 255 and then wraps to 0,
                        // which is midnight and ends the ramp.
                        if (r_step_cnt == STEP_LAST) begin
                            w_step_nxt = '0;
                            w_fade_nxt = w_fade_inc;
                            if (w_fade_inc == FADE_MIDNIGHT) begin
                                w_state_nxt = S_NIGHT_HOLD;
                            end
                        end else begin
                            w_step_nxt = r_step_cnt + SW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Skip capture: consumed by an unpaused tick, otherwise latched. This
    // is the only state that changes between ticks.
    always_comb begin
        w_skip_pend_nxt = r_skip_pend;
        if (w_advance) begin
            w_skip_pend_nxt = 1'b0;
        end else if (bus.skip) begin
            w_skip_pend_nxt = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_state     <= S_NIGHT_HOLD;
            r_fade      <= FADE_MIDNIGHT;
            r_frame_cnt <= '0;
            r_lfsr      <= LFSR_SEED;
            r_star_mask <= '0;
            r_hold_cnt  <= '0;
            r_step_cnt  <= '0;
            r_skip_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fade      <= w_fade_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_step_cnt  <= w_step_nxt;
            r_skip_pend <= w_skip_pend_nxt;
            if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_lfsr      <= w_lfsr_adv;
                // Refresh the twinkle pattern once every 16 frames using
                // the LFSR value from before this tick's advance.
                if (r_frame_cnt[3:0] == 4'hF) begin
                    r_star_mask <= r_lfsr[NSTARS-1:0];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign w_is_night = (r_fade < 8'd64) || (r_fade > 8'd208);

    assign bus.fade_level  = r_fade;
    assign bus.frame_count = r_frame_cnt;
    assign bus.phase       = r_state;
    assign bus.is_night    = w_is_night;
    assign bus.star_en     = r_star_mask & {NSTARS{w_is_night}};

endmodule

// File: tb/tb_sky_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sky_cycle_ctrl
//   Scoreboard bench for sky_cycle_ctrl. Every reset or frame cycle the
//   driver advances a behavioural model and pushes the expected outputs;
//   a monitor on the falling edge pops and compares. Directed checks mark
//   the milestones of the day/night cycle.
// ---------------------------------------------------------------------------
module tb_sky_cycle_ctrl;
    localparam int HOLD = 4;
    localparam int STEP = 2;
    localparam int NS   = 12;
    localparam int W    = 8 + 16 + 2 + 1 + NS;
    localparam logic [15:0] SEED = 16'hACE1;

    // ---------------- clock / reset ----------------
    logic clk_pix = 1'b0;
    logic rst     = 1'b0;
    always #5 clk_pix = ~clk_pix;

    sky_cycle_ctrl_if #(.NSTARS(NS)) bus ();

    sky_cycle_ctrl #(
        .HOLD_FRAMES(HOLD),
        .STEP_FRAMES(STEP),
        .NSTARS     (NS),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk_pix(clk_pix),
        .rst    (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Phase numbers: 0 night hold, 1 morning, 2 day hold, 3 evening.
    int            m_phase, m_fade, m_hold, m_step, m_fc;
    bit            m_pend;
    logic [15:0]   m_lfsr;
    logic [NS-1:0] m_mask;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic bit night_of(input int f);
        return (f < 64) || (f > 208);
    endfunction

    function automatic logic [W-1:0] model_pack();
        bit n;
        logic [NS-1:0] se;
        n  = night_of(m_fade);
        se = n ? m_mask : '0;
        return {8'(m_fade), 16'(m_fc), 2'(m_phase), n, se};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_fade = 0; m_hold = 0; m_step = 0; m_fc = 0;
        m_pend = 0; m_lfsr = SEED; m_mask = '0;
    endtask

    task automatic model_tick(input bit p, input bit s);
        bit eff;
        if ((m_fc % 16) == 15) m_mask = m_lfsr[NS-1:0];
        m_lfsr = lfsr_next(m_lfsr);
        m_fc   = (m_fc + 1) % 65536;
        eff    = m_pend || s;
        if (p) begin
            m_pend = eff;
        end else begin
            m_pend = 0;
            if (eff) begin
                m_phase = (m_phase + 1) % 4;
                m_fade  = (m_phase == 2 || m_phase == 3) ? 128 : 0;
                m_hold  = 0;
                m_step  = 0;
            end else if (m_phase == 0 || m_phase == 2) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_hold  = 0;
                    m_phase = m_phase + 1;
                end
            end else begin
                m_step++;
                if (m_step == STEP) begin
                    m_step = 0;
                    m_fade = (m_fade + 1) % 256;
                    if ((m_phase == 1 && m_fade == 128) || (m_phase == 3 && m_fade == 0))
                        m_phase = (m_phase + 1) % 4;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the next one.
    task automatic drive(input bit r, input bit f, input bit p, input bit s);
        rst = r; bus.frame = f; bus.pause = p; bus.skip = s;
        if (r)      model_reset();
        else if (f) model_tick(p, s);
        else if (s) m_pend = 1;
        if (r || f) exp_q.push_back(model_pack());
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic         tick_seen = 1'b0;
    logic [W-1:0] e_v, a_v;

    always @(posedge clk_pix) tick_seen <= bus.frame | rst;

    always @(negedge clk_pix) begin
        if (tick_seen) begin
            total++;
            a_v = {bus.fade_level, bus.frame_count, bus.phase, bus.is_night, bus.star_en};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: got %0h expected nothing queued", a_v);
            end else begin
                e_v = exp_q.pop_front();
                if (a_v !== e_v) begin
                    bad++;
                    $display("FAIL sb at %0t: got {fade,fc,ph,n,st}=%0h expected %0h", $time, a_v, e_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] l15;
    int          fc_base;
    int          guard;
    int          r;

    initial begin
        bus.frame = 1'b0; bus.pause = 1'b0; bus.skip = 1'b0;
        model_reset();
        @(posedge clk_pix); #1;

        // Reset with frame high (and a skip) for two cycles.
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 1);
        chk("rst_fade",  bus.fade_level,  0);
        chk("rst_fc",    bus.frame_count, 0);
        chk("rst_phase", bus.phase,       0);
        chk("rst_night", bus.is_night,    1);
        chk("rst_star",  bus.star_en,     0);

        l15 = SEED;
        repeat (15) l15 = lfsr_next(l15);

        // One full cycle: 2*4 + 256*2 = 520 ticks.
        for (int k = 1; k <= 520; k++) begin
            drive(0, 1, 0, 0);
            if (k == 4)   begin chk("t4_phase", bus.phase, 1); chk("t4_fade", bus.fade_level, 0); end
            if (k == 6)   chk("t6_fade", bus.fade_level, 1);
            if (k == 16)  begin chk("t16_star", bus.star_en, {20'h0, l15[NS-1:0]}); chk("t16_night", bus.is_night, 1); end
            if (k == 200) chk("t200_star_day", bus.star_en, 0);
            if (k == 260) begin
                chk("t260_fade", bus.fade_level, 128);
                chk("t260_phase", bus.phase, 2);
                chk("t260_night", bus.is_night, 0);
            end
            if (k == 264) chk("t264_phase", bus.phase, 3);
            if (k == 520) begin
                chk("t520_fade", bus.fade_level, 0);
                chk("t520_phase", bus.phase, 0);
                chk("t520_fc", bus.frame_count, 520);
            end
        end

        // Pause in the morning ramp at fade 37.
        guard = 0;
        while (!(m_phase == 1 && m_fade == 37 && m_step == 0) && guard < 2000) begin
            drive(0, 1, 0, 0);
            guard++;
        end
        chk("pause_reach", guard < 2000, 1);
        fc_base = m_fc;
        repeat (10) drive(0, 1, 1, 0);
        chk("pause_fade",  bus.fade_level, 37);
        chk("pause_phase", bus.phase, 1);
        chk("pause_fc",    bus.frame_count, (fc_base + 10) % 65536);
        drive(0, 1, 0, 0);
        chk("rel1_fade", bus.fade_level, 37);
        drive(0, 1, 0, 0);
        chk("rel2_fade", bus.fade_level, 38);

        // Skip pulse between ticks during the morning ramp.
        drive(0, 0, 0, 1);
        drive(0, 1, 0, 0);
        chk("skipm_fade",  bus.fade_level, 128);
        chk("skipm_phase", bus.phase, 2);

        // Skip while paused waits for the first unpaused tick.
        drive(0, 1, 1, 1);
        chk("skipp_hold1", bus.phase, 2);
        drive(0, 1, 1, 0);
        chk("skipp_hold2", bus.phase, 2);
        drive(0, 1, 0, 0);
        chk("skipp_phase", bus.phase, 3);
        chk("skipp_fade",  bus.fade_level, 128);

        // Skip in the evening ramp.
        repeat (5) drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        chk("skipe_fade",  bus.fade_level, 0);
        chk("skipe_phase", bus.phase, 0);

        // Random mix of ticks, idles, pauses and skips.
        repeat (400) begin
            r = $urandom_range(0, 15);
            if (r == 0)      drive(0, 0, 0, 1);
            else if (r < 3)  drive(0, 0, 0, 0);
            else             drive(0, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
        end

        // frame_count wrap.
        guard = 0;
        while (m_fc != 16'hFFFF && guard < 70000) begin
            drive(0, 1, 0, 0);
            guard++;
        end
        chk("wrap_pre", bus.frame_count, 16'hFFFF);
        drive(0, 1, 0, 0);
        chk("wrap_fc", bus.frame_count, 0);

        // Reset in the evening coincident with tick and skip, with a skip
        // already pending: nothing of it must survive.
        guard = 0;
        while (m_phase != 3 && guard < 8) begin
            drive(0, 1, 0, 1);
            guard++;
        end
        chk("eve_reach", bus.phase, 3);
        drive(0, 0, 0, 1);
        drive(1, 1, 0, 1);
        chk("rst2_fade",  bus.fade_level, 0);
        chk("rst2_phase", bus.phase, 0);
        chk("rst2_fc",    bus.frame_count, 0);
        chk("rst2_star",  bus.star_en, 0);
        drive(0, 1, 0, 0);
        chk("rst2_noskip", bus.phase, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("rst2_hold3", bus.phase, 0);
        drive(0, 1, 0, 0);
        chk("rst2_morn", bus.phase, 1);
        chk("rst2_fc4", bus.frame_count, 4);

        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk_pix);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
